freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Gated frequency counter; inverse of the NCO path: measures a square-wave input and reports frequency in Hz in the same 20-bit units as the generator's frequency word.
- Used for loopback self-check of generated waveforms and for measuring external reference inputs.
- Counts synchronized rising edges over a fixed gate window, scales the count by the gate ratio, saturates, and presents the result with a one-cycle valid strobe.

Parameters:
- GATE_CYCLES, 100_000_000, clk cycles in the 1 s gate; must be divisible by 100; benches use 1000
- CNT_W, 27, internal edge-counter width; must hold GATE_CYCLES/2
- OUT_W, 20, width of freq_hz

Ports:
- clk  in  1  system clock (100 MHz nominal)
- rst_n  in  1  reset; asynchronous, active-low
- sig_in  in  1  measured signal; asynchronous to clk
- enable  in  1  level; high = measure continuously
- gate_sel  in  2  0 = GATE_CYCLES (x1), 1 = GATE_CYCLES/10 (x10), 2 = GATE_CYCLES/100 (x100), 3 = same as 0
- freq_hz  out  OUT_W  last measured frequency, saturated
- freq_valid  out  1  one-cycle pulse when freq_hz updates
- overflow  out  1  scaled result exceeded 2^OUT_W-1 in last measurement
- busy  out  1  high while a gate window is open

Behaviour:
- Reset: freq_hz=0, freq_valid=0, overflow=0, busy=0, FSM=IDLE, counters=0, sync/edge flops=0.
- Input path:
  - 2-FF synchronizer, then a previous-value flop.
  - edge_pulse = sync & ~prev.
  - A sig_in rise reaches edge_pulse on the 3rd clk edge after it, with input setup met.
- FSM states: IDLE, COUNT, REPORT.
- IDLE:
  - busy=0.
  - When enable=1, next cycle goes to COUNT.
  - Entering COUNT: latch gate_sel into sel_q, load gate_cnt = window(sel_q)-1, clear edge_cnt.
- COUNT:
  - busy=1.
  - Each cycle, edge_pulse increments edge_cnt, saturating at 2^CNT_W-1.
  - gate_cnt decrements each cycle. The window is exactly window(sel_q) cycles, including the cycle gate_cnt==0.
  - An edge_pulse in the final cycle is counted.
  - enable=0 in any COUNT cycle: abort to IDLE next cycle. No freq_valid; freq_hz and overflow hold.
  - gate_cnt==0 with enable=1: go to REPORT. The final-cycle edge is included in the count.
- REPORT (exactly 1 cycle):
  - scaled = final edge_cnt * {1,10,100}[sel_q], computed at CNT_W+7 bits.
  - Multiplies by 10 and 100 use shift-add (x8+x2, x64+x32+x4); no DSP multiplier required.
  - If scaled > 2^OUT_W-1: freq_hz = all ones, overflow=1. Otherwise freq_hz = scaled, overflow=0.
  - freq_valid=1 in the cycle after REPORT, aligned with the new freq_hz/overflow values (registered outputs).
  - busy=0 in REPORT.
  - Next state: COUNT (re-latch gate_sel) if enable=1, else IDLE.
  - Edges falling in the REPORT cycle are not counted; dead time is 1 cycle per measurement.
- gate_sel changes mid-window: ignored until the next window start.
- Latency: the first freq_valid arrives window+2 cycles after enable first samples high.
- Measurement rate: one result every window+1 cycles while enable stays high.
- sig_in static: result is 0 with freq_valid still pulsed.
- Maximum countable rate is clk/2; higher input rates alias, with no requirement beyond the saturation rules.
- Reset mid-window: immediate return to the reset values; the partial count is discarded.

Decomposition:
- Shared package (wavegen_pkg):
  - gate_sel encodings GATE_1S=0, GATE_100MS=1, GATE_10MS=2
  - FSM state typedef {IDLE, COUNT, REPORT}
  - CLK_HZ = 100_000_000
- One sub-module, edge_sync:
  - 2-FF synchronizer plus rising-edge detector; clk, rst_n, async_in -> edge_pulse.
  - Reused by other asynchronous-input blocks.

Test Plan:
- GATE_CYCLES=1000, gate_sel=0, sig_in period 10 clk, enable held high -> freq_valid after 1002 cycles with freq_hz=100, overflow=0; identical result every 1001 cycles.
- gate_sel=1 (window 100), sig_in period 10 -> edge_cnt 10, freq_hz=100. gate_sel=2 (window 10), period 5 -> edge_cnt 2, freq_hz=200.
- OUT_W=8, gate_sel=0, sig_in period 2 -> count 500 -> freq_hz=255, overflow=1. Next window at period 10 -> freq_hz=100, overflow=0.
- Drop enable at cycle 500 of a window -> no freq_valid, busy falls, freq_hz keeps its previous value. Re-enable -> full new window, correct value.
- Single sig_in rise timed so edge_pulse lands exactly on the final gate cycle -> freq_hz=1. Timed to land in the REPORT cycle -> freq_hz=0 for that window, and not counted in the next.
- Assert rst_n low mid-COUNT with edges running -> all outputs 0 the same cycle. After release with enable=1, the first result is correct and no stale count leaks through.

Source files
------------

// File: rtl/wavegen_pkg.sv
// ============================================================================
// Module   : wavegen_pkg
// Purpose  : Shared gate encodings, measurement FSM states and system clock rate.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wavegen_pkg;

   localparam int unsigned CLK_HZ = 100_000_000;

   localparam logic [1:0] GATE_1S    = 2'd0;
   localparam logic [1:0] GATE_100MS = 2'd1;
   localparam logic [1:0] GATE_10MS  = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      REPORT = 2'd2
   } meter_state_e;

endpackage

`default_nettype wire

// File: rtl/edge_sync.sv
// ============================================================================
// Module   : edge_sync
// Purpose  : Two-flop synchronizer followed by a rising-edge detector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module edge_sync
   import wavegen_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic edge_pulse
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= async_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign edge_pulse = sync2_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/freq_meter.sv
// ============================================================================
// Module   : freq_meter
// Purpose  : Gated edge counter; scales the count by the gate ratio and reports Hz.
// Revision : 1.0
// ============================================================================
`default_nettype none

module freq_meter
   import wavegen_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = 100_000_000,
   parameter int unsigned CNT_W       = 27,
   parameter int unsigned OUT_W       = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig_in,
   input  logic             enable,
   input  logic [1:0]       gate_sel,
   output logic [OUT_W-1:0] freq_hz,
   output logic             freq_valid,
   output logic             overflow,
   output logic             busy
);

   localparam int unsigned GW = $clog2(GATE_CYCLES);
   localparam int unsigned SW = CNT_W + 7;

   localparam logic [GW-1:0] WIN_X1_M1   = GW'(GATE_CYCLES - 1);
   localparam logic [GW-1:0] WIN_X10_M1  = GW'(GATE_CYCLES / 10 - 1);
   localparam logic [GW-1:0] WIN_X100_M1 = GW'(GATE_CYCLES / 100 - 1);
   localparam logic [SW-1:0] OUT_MAX     = SW'((64'd1 << OUT_W) - 64'd1);

   meter_state_e     state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [OUT_W-1:0] freq_hz_q, freq_hz_d;
   logic             overflow_q, overflow_d;
   logic             freq_valid_q, freq_valid_d;

   logic             edge_pulse;
   logic             start;
   logic [GW-1:0]    win_m1;
   logic [SW-1:0]    edge_ext;
   logic [SW-1:0]    scaled;

   edge_sync u_edge_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .async_in   (sig_in),
      .edge_pulse (edge_pulse)
   );

   always_comb begin
      win_m1 = WIN_X1_M1;
      case (gate_sel)
         GATE_100MS: win_m1 = WIN_X10_M1;
         GATE_10MS:  win_m1 = WIN_X100_M1;
         default:    win_m1 = WIN_X1_M1;
      endcase
   end

   // Shift-add scaling keeps the x10/x100 paths out of DSP multipliers.
   assign edge_ext = SW'(edge_cnt_q);
   always_comb begin
      scaled = edge_ext;
      case (sel_q)
         GATE_100MS: scaled = (edge_ext << 3) + (edge_ext << 1);
         GATE_10MS:  scaled = (edge_ext << 6) + (edge_ext << 5) + (edge_ext << 2);
         default:    scaled = edge_ext;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      gate_cnt_d   = gate_cnt_q;
      edge_cnt_d   = edge_cnt_q;
      freq_hz_d    = freq_hz_q;
      overflow_d   = overflow_q;
      freq_valid_d = 1'b0;
      start        = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable) start = 1'b1;
         end
         COUNT: begin
            if (!enable) begin
               state_d = IDLE;
            end else begin
               if (edge_pulse && (edge_cnt_q != {CNT_W{1'b1}}))
                  edge_cnt_d = edge_cnt_q + CNT_W'(1);
               gate_cnt_d = gate_cnt_q - GW'(1);
               if (gate_cnt_q == '0) state_d = REPORT;
            end
         end
         REPORT: begin
            freq_valid_d = 1'b1;
            if (scaled > OUT_MAX) begin
               freq_hz_d  = {OUT_W{1'b1}};
               overflow_d = 1'b1;
            end else begin
               freq_hz_d  = scaled[OUT_W-1:0];
               overflow_d = 1'b0;
            end
            if (enable) start = 1'b1;
            else        state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A new window re-latches the gate selection and restarts both counters.
      if (start) begin
         state_d    = COUNT;
         sel_d      = gate_sel;
         gate_cnt_d = win_m1;
         edge_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sel_q        <= GATE_1S;
         gate_cnt_q   <= '0;
         edge_cnt_q   <= '0;
         freq_hz_q    <= '0;
         overflow_q   <= 1'b0;
         freq_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         gate_cnt_q   <= gate_cnt_d;
         edge_cnt_q   <= edge_cnt_d;
         freq_hz_q    <= freq_hz_d;
         overflow_q   <= overflow_d;
         freq_valid_q <= freq_valid_d;
      end
   end

   assign freq_hz    = freq_hz_q;
   assign overflow   = overflow_q;
   assign freq_valid = freq_valid_q;
   assign busy       = (state_q == COUNT);

endmodule

`default_nettype wire

// File: tb/tb_freq_meter.sv
// ============================================================================
// Module   : tb_freq_meter
// Purpose  : Directed scoreboard bench for freq_meter with a 1000-cycle gate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_freq_meter;
   import wavegen_pkg::*;

   localparam int unsigned GATE  = 1000;
   localparam int unsigned OUT_W = 8;

   logic             clk      = 1'b0;
   logic             rst_n    = 1'b0;
   logic             sig_in   = 1'b0;
   logic             enable   = 1'b0;
   logic [1:0]       gate_sel = 2'd0;
   logic [OUT_W-1:0] freq_hz;
   logic             freq_valid;
   logic             overflow;
   logic             busy;

   freq_meter #(
      .GATE_CYCLES (GATE),
      .CNT_W       (27),
      .OUT_W       (OUT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sig_in     (sig_in),
      .enable     (enable),
      .gate_sel   (gate_sel),
      .freq_hz    (freq_hz),
      .freq_valid (freq_valid),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [OUT_W-1:0] hz;
      logic             ov;
   } exp_t;

   exp_t sb_q[$];
   int   checks         = 0;
   int   fails          = 0;
   int   cyc            = 0;
   int   valid_cnt      = 0;
   int   last_valid_cyc = 0;
   int   gen_period     = 0;
   logic man_level      = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Square-wave source; period 0 hands the pin to man_level for timed single edges.
   initial begin
      int phase;
      phase = 0;
      forever begin
         @(posedge clk);
         #2;
         if (gen_period == 0) begin
            sig_in = man_level;
            phase  = 0;
         end else begin
            if (phase >= gen_period) phase = 0;
            sig_in = (phase < gen_period / 2);
            phase++;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input int hz, input logic ov);
      exp_t e;
      e.hz = OUT_W'(hz);
      e.ov = ov;
      sb_q.push_back(e);
   endtask

   task automatic wait_valids(input int n, input int budget);
      int target;
      int k;
      target = valid_cnt + n;
      k      = 0;
      while (valid_cnt < target && k < budget) begin
         @(posedge clk);
         k++;
      end
      if (valid_cnt < target) begin
         checks++;
         fails++;
         $display("FAIL valid_timeout: got %0d results, expected %0d", valid_cnt, target);
      end
   endtask

   task automatic gap(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every result strobe is matched against the next scoreboard entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (freq_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            if (sb_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_valid: got freq_hz=%0d overflow=%0d, expected no result",
                        freq_hz, overflow);
            end else begin
               e = sb_q.pop_front();
               check("freq_hz", int'(freq_hz), int'(e.hz));
               check("overflow", int'(overflow), int'(e.ov));
            end
         end
      end
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int tp;
      int vc;

      rst_n = 1'b0;
      gap(3);
      check("rst_freq_hz", int'(freq_hz), 0);
      check("rst_valid", int'(freq_valid), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_busy", int'(busy), 0);
      rst_n = 1'b1;

      // Continuous x1 measurement at period 10
      gate_sel   = GATE_1S;
      gen_period = 10;
      gap(20);
      repeat (3) push_exp(100, 1'b0);
      enable = 1'b1;
      t0     = cyc;
      gap(10);
      check("busy_in_window", int'(busy), 1);
      wait_valids(1, 1100);
      check("first_latency", last_valid_cyc - t0, 1002);
      tp = last_valid_cyc;
      wait_valids(1, 1100);
      check("interval_1", last_valid_cyc - tp, 1001);
      tp = last_valid_cyc;
      wait_valids(1, 1100);
      check("interval_2", last_valid_cyc - tp, 1001);
      @(negedge clk);
      enable = 1'b0;

      // x10 window; a mid-window gate_sel change must be ignored
      gap(20);
      gate_sel = GATE_100MS;
      push_exp(100, 1'b0);
      enable = 1'b1;
      t0     = cyc;
      gap(5);
      gate_sel = GATE_1S;
      wait_valids(1, 200);
      check("x10_latency", last_valid_cyc - t0, 102);
      @(negedge clk);
      enable = 1'b0;

      // x100 window at period 5
      gate_sel   = GATE_10MS;
      gen_period = 5;
      gap(20);
      push_exp(200, 1'b0);
      enable = 1'b1;
      wait_valids(1, 50);
      @(negedge clk);
      enable = 1'b0;

      // Saturation with OUT_W=8, then recovery
      gate_sel   = GATE_1S;
      gen_period = 2;
      gap(20);
      push_exp(255, 1'b1);
      enable = 1'b1;
      wait_valids(1, 1100);
      @(negedge clk);
      enable     = 1'b0;
      gen_period = 10;
      gap(20);
      push_exp(100, 1'b0);
      enable = 1'b1;
      wait_valids(1, 1100);
      @(negedge clk);
      enable = 1'b0;

      // Abort mid-window
      gen_period = 5;
      gap(20);
      enable = 1'b1;
      gap(500);
      enable = 1'b0;
      vc     = valid_cnt;
      gap(2);
      check("abort_busy", int'(busy), 0);
      gap(1100);
      check("abort_no_valid", valid_cnt - vc, 0);
      check("abort_hold_hz", int'(freq_hz), 100);
      push_exp(200, 1'b0);
      enable = 1'b1;
      t0     = cyc;
      wait_valids(1, 1100);
      check("reenable_latency", last_valid_cyc - t0, 1002);
      @(negedge clk);
      enable = 1'b0;

      // Reset mid-window with edges running
      gen_period = 2;
      gap(20);
      enable = 1'b1;
      gap(300);
      check("busy_before_rst", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("midrst_freq_hz", int'(freq_hz), 0);
      check("midrst_overflow", int'(overflow), 0);
      check("midrst_valid", int'(freq_valid), 0);
      check("midrst_busy", int'(busy), 0);
      gap(3);
      enable     = 1'b0;
      gen_period = 10;
      rst_n      = 1'b1;
      gap(20);
      push_exp(100, 1'b0);
      enable = 1'b1;
      t0     = cyc;
      wait_valids(1, 1100);
      check("post_rst_latency", last_valid_cyc - t0, 1002);
      @(negedge clk);
      enable = 1'b0;

      // Single rise counted in the final gate cycle
      gen_period = 0;
      man_level  = 1'b0;
      gap(20);
      push_exp(1, 1'b0);
      enable = 1'b1;
      repeat (998) @(posedge clk);
      man_level = 1'b1;
      wait_valids(1, 100);
      @(negedge clk);
      enable    = 1'b0;
      man_level = 1'b0;
      gap(20);

      // Single rise landing in the REPORT cycle: lost, and not carried forward
      push_exp(0, 1'b0);
      push_exp(0, 1'b0);
      enable = 1'b1;
      repeat (999) @(posedge clk);
      man_level = 1'b1;
      wait_valids(2, 2200);
      @(negedge clk);
      enable    = 1'b0;
      man_level = 1'b0;

      gap(5);
      check("scoreboard_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire
